tb_ctrl_periph: RTL and testbench

- Memory-mapped test-control responder on the core's data bus inside the simulation subsystem.
- Firmware writes to it to report pass/fail/exit and to stream stdout characters.
- It drives the tests_passed / tests_failed / exit_valid / exit_value status that the top-level bench monitors to end simulation.
- stdout bytes are buffered in a small FIFO and drained through a valid/ready character port.

---
 rtl/tb_ctrl_periph.sv | 150 +++++++++++++++
 tb/tb_tb_ctrl_periph.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tb_ctrl_periph.sv
// Test-control responder on the core data bus: sticky pass/fail/exit status, a free-running
// cycle counter, and a small stdout FIFO drained through a valid/ready character port.
module tb_ctrl_periph #(
    parameter logic [31:0] BASE_ADDR  = 32'h2000_0000,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] PASS_MAGIC = 32'd123456789
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        char_valid_o,
    output logic [7:0]  char_o,
    input  logic        char_ready_i,
    output logic        tests_passed_o,
    output logic        tests_failed_o,
    output logic        exit_valid_o,
    output logic [31:0] exit_value_o
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    localparam logic [7:0] OffStdout = 8'h00;
    localparam logic [7:0] OffTest   = 8'h04;
    localparam logic [7:0] OffExit   = 8'h08;
    localparam logic [7:0] OffCycles = 8'h10;
    localparam logic [7:0] OffStatus = 8'h14;

    logic [7:0]      off;
    logic            hit, stdout_wr, word_wr, gnt, push, pop, full, empty, done;
    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [31:0]     cycle_q;
    logic            rvalid_q, err_q, err_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            passed_q, passed_d, failed_q, failed_d, exit_valid_q, exit_valid_d;
    logic [31:0]     exit_value_q, exit_value_d;

    assign hit       = data_addr_i[31:8] == BASE_ADDR[31:8];
    assign off       = data_addr_i[7:0];
    assign stdout_wr = hit && (off == OffStdout) && data_we_i && data_be_i[0];
    assign word_wr   = hit && data_we_i && (data_be_i == 4'hF) && !done;

    assign full  = cnt_q == CntW'(FIFO_DEPTH);
    assign empty = cnt_q == '0;
    assign done  = passed_q | failed_q | exit_valid_q;

    // A blocked STDOUT write stays ungranted even if a pop frees a slot this cycle.
    assign gnt  = data_req_i && !(stdout_wr && full);
    assign push = gnt && stdout_wr;
    assign pop  = !empty && char_ready_i;

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push && pop) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // First terminating event wins; later TEST/EXIT writes are absorbed by !done.
    always_comb begin
        passed_d     = passed_q;
        failed_d     = failed_q;
        exit_valid_d = exit_valid_q;
        exit_value_d = exit_value_q;
        if (gnt && word_wr) begin
            if (off == OffTest) begin
                if (data_wdata_i == PASS_MAGIC) begin
                    passed_d = 1'b1;
                end else if (data_wdata_i == 32'd1) begin
                    failed_d = 1'b1;
                end
            end else if (off == OffExit) begin
                exit_valid_d = 1'b1;
                exit_value_d = data_wdata_i;
            end
        end
    end

    always_comb begin
        rdata_d = '0;
        err_d   = 1'b0;
        if (gnt) begin
            if (!hit) begin
                err_d = 1'b1;
            end else begin
                case (off)
                    OffStdout, OffTest, OffExit: ;
                    OffCycles: if (!data_we_i) rdata_d = cycle_q;
                    OffStatus: if (!data_we_i) rdata_d = {15'd0, done, 8'(cnt_q), 6'd0, full, empty};
                    default:   err_d = 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cycle_q      <= '0;
            cnt_q        <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            passed_q     <= 1'b0;
            failed_q     <= 1'b0;
            exit_valid_q <= 1'b0;
            exit_value_q <= '0;
        end else begin
            cycle_q      <= cycle_q + 32'd1;
            cnt_q        <= cnt_d;
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            rvalid_q     <= gnt;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            passed_q     <= passed_d;
            failed_q     <= failed_d;
            exit_valid_q <= exit_valid_d;
            exit_value_q <= exit_value_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= data_wdata_i[7:0];
    end

    assign data_gnt_o     = gnt;
    assign data_rvalid_o  = rvalid_q;
    assign data_rdata_o   = rdata_q;
    assign data_err_o     = err_q;
    assign char_valid_o   = !empty;
    assign char_o         = empty ? 8'h00 : mem_q[rptr_q];
    assign tests_passed_o = passed_q;
    assign tests_failed_o = failed_q;
    assign exit_valid_o   = exit_valid_q;
    assign exit_value_o   = exit_value_q;
endmodule

// File: tb/tb_tb_ctrl_periph.sv
// Bench for tb_ctrl_periph: register-map vector table, directed FIFO/sticky/reset sequences
// and randomized bus traffic checked against a queue-based reference model.
module tb_tb_ctrl_periph;
    localparam logic [31:0] BASE  = 32'h2000_0000;
    localparam int          DEPTH = 8;
    localparam logic [31:0] MAGIC = 32'd123456789;

    logic        clk_i = 1'b0, rst_i = 1'b1;
    logic        data_req_i = 1'b0, data_we_i = 1'b0, char_ready_i = 1'b0;
    logic [31:0] data_addr_i = '0, data_wdata_i = '0;
    logic [3:0]  data_be_i = '0;
    logic        data_gnt_o, data_rvalid_o, data_err_o, char_valid_o;
    logic        tests_passed_o, tests_failed_o, exit_valid_o;
    logic [31:0] data_rdata_o, exit_value_o;
    logic [7:0]  char_o;

    tb_ctrl_periph #(
        .BASE_ADDR (BASE),
        .FIFO_DEPTH(DEPTH),
        .PASS_MAGIC(MAGIC)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .data_req_i    (data_req_i),
        .data_gnt_o    (data_gnt_o),
        .data_addr_i   (data_addr_i),
        .data_we_i     (data_we_i),
        .data_be_i     (data_be_i),
        .data_wdata_i  (data_wdata_i),
        .data_rvalid_o (data_rvalid_o),
        .data_rdata_o  (data_rdata_o),
        .data_err_o    (data_err_o),
        .char_valid_o  (char_valid_o),
        .char_o        (char_o),
        .char_ready_i  (char_ready_i),
        .tests_passed_o(tests_passed_o),
        .tests_failed_o(tests_failed_o),
        .exit_valid_o  (exit_valid_o),
        .exit_value_o  (exit_value_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs[NVEC];

    int n_checks = 0, n_fail = 0, n_pops = 0;

    // Reference model: FIFO as a queue, flags, and a count of clock edges since reset.
    logic [7:0]  mq[$];
    logic        m_pass, m_fail, m_exit;
    logic [31:0] m_exitv;
    int unsigned m_cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        check(name, {31'd0, act}, {31'd0, exp});
    endtask

    task automatic check_flags(input string tag);
        check_b({tag, "_passed"}, tests_passed_o, m_pass);
        check_b({tag, "_failed"}, tests_failed_o, m_fail);
        check_b({tag, "_exit_valid"}, exit_valid_o, m_exit);
        check({tag, "_exit_value"}, exit_value_o, m_exitv);
    endtask

    task automatic check_all_zero(input string tag);
        check_b({tag, "_gnt"}, data_gnt_o, 1'b0);
        check_b({tag, "_rvalid"}, data_rvalid_o, 1'b0);
        check({tag, "_rdata"}, data_rdata_o, 32'h0);
        check_b({tag, "_err"}, data_err_o, 1'b0);
        check_b({tag, "_char_valid"}, char_valid_o, 1'b0);
        check({tag, "_char"}, {24'd0, char_o}, 32'h0);
        check_b({tag, "_passed"}, tests_passed_o, 1'b0);
        check_b({tag, "_failed"}, tests_failed_o, 1'b0);
        check_b({tag, "_exit_valid"}, exit_valid_o, 1'b0);
        check({tag, "_exit_value"}, exit_value_o, 32'h0);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        data_req_i = 1'b0;
        char_ready_i = 1'b0;
        mq.delete();
        m_pass = 1'b0; m_fail = 1'b0; m_exit = 1'b0; m_exitv = '0; m_cyc = 0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    // One clock from negedge to negedge; snapshot the pre-edge state, retire a model pop.
    task automatic step(output logic g, output int unsigned cyc, output int cnt, output logic dn);
        #4;
        g = data_gnt_o;
        cyc = m_cyc;
        cnt = mq.size();
        dn = m_pass | m_fail | m_exit;
        if (!rst_i) begin
            check_b("char_valid", char_valid_o, mq.size() != 0);
            if (char_ready_i && mq.size() != 0) begin
                check("char_data", {24'd0, char_o}, {24'd0, mq[0]});
                void'(mq.pop_front());
                n_pops++;
            end
        end
        @(negedge clk_i);
        if (!rst_i) m_cyc++;
    endtask

    task automatic idle(input int n);
        logic g, dn;
        int unsigned cyc;
        int cnt;
        repeat (n) step(g, cyc, cnt, dn);
    endtask

    task automatic bus_op(input logic [31:0] addr, input logic we, input logic [3:0] be,
                          input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
        logic g, dn, hit, is_push, exp_err;
        logic [31:0] exp_rd;
        int unsigned cyc;
        int cnt, n;
        data_req_i = 1'b1; data_addr_i = addr; data_we_i = we; data_be_i = be;
        data_wdata_i = wdata;
        hit = addr[31:8] == BASE[31:8];
        is_push = hit && addr[7:0] == 8'h00 && we && be[0];
        n = 0;
        forever begin
            step(g, cyc, cnt, dn);
            check_b("gnt", g, !(is_push && cnt == DEPTH));
            if (g || n >= 50) break;
            n++;
        end
        data_req_i = 1'b0;
        rdata = data_rdata_o;
        err = data_err_o;
        if (!g) begin
            check_b("gnt_timeout", g, 1'b1);
            return;
        end
        exp_rd = '0;
        exp_err = 1'b0;
        if (!hit) begin
            exp_err = 1'b1;
        end else begin
            case (addr[7:0])
                8'h00: if (is_push) mq.push_back(wdata[7:0]);
                8'h04: if (we && be == 4'hF && !dn) begin
                    if (wdata == MAGIC) m_pass = 1'b1;
                    else if (wdata == 32'd1) m_fail = 1'b1;
                end
                8'h08: if (we && be == 4'hF && !dn) begin
                    m_exit = 1'b1;
                    m_exitv = wdata;
                end
                8'h10: if (!we) exp_rd = cyc;
                8'h14: if (!we) exp_rd = 32'(cnt * 256 + (cnt == DEPTH ? 2 : 0)
                                             + (cnt == 0 ? 1 : 0) + (dn ? 65536 : 0));
                default: exp_err = 1'b1;
            endcase
        end
        check_b("rvalid", data_rvalid_o, 1'b1);
        check("rdata", rdata, exp_rd);
        check_b("err", err, exp_err);
        check_flags("op");
    endtask

    logic [31:0] rd, wd, addr;
    logic        er, g, dn, we;
    logic [3:0]  be;
    int unsigned cyc;
    int          cnt, pops0, kind;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{BASE + 32'h00, 1'b0, 4'hF, 32'h0,     32'h0, 1'b0};
        vecs[1]  = '{BASE + 32'h04, 1'b0, 4'hF, 32'h0,     32'h0, 1'b0};
        vecs[2]  = '{BASE + 32'h08, 1'b0, 4'hF, 32'h0,     32'h0, 1'b0};
        vecs[3]  = '{BASE + 32'h14, 1'b0, 4'hF, 32'h0,     32'h1, 1'b0};
        vecs[4]  = '{BASE + 32'h10, 1'b1, 4'hF, 32'h55,    32'h0, 1'b0};
        vecs[5]  = '{BASE + 32'h14, 1'b1, 4'hF, 32'h55,    32'h0, 1'b0};
        vecs[6]  = '{BASE + 32'h20, 1'b0, 4'hF, 32'h0,     32'h0, 1'b1};
        vecs[7]  = '{BASE + 32'h0C, 1'b0, 4'hF, 32'h0,     32'h0, 1'b1};
        vecs[8]  = '{BASE + 32'hFC, 1'b1, 4'hF, 32'h1,     32'h0, 1'b1};
        vecs[9]  = '{32'h3000_0004, 1'b0, 4'hF, 32'h0,     32'h0, 1'b1};
        vecs[10] = '{32'h2000_0100, 1'b1, 4'h1, 32'h41,    32'h0, 1'b1};
        vecs[11] = '{BASE + 32'h04, 1'b1, 4'h1, MAGIC,     32'h0, 1'b0};
        vecs[12] = '{BASE + 32'h08, 1'b1, 4'h3, 32'h7,     32'h0, 1'b0};
        vecs[13] = '{BASE + 32'h00, 1'b1, 4'h2, 32'h42,    32'h0, 1'b0};

        @(negedge clk_i);
        do_reset();
        idle(10);
        check_all_zero("reset_idle");
        bus_op(BASE + 32'h14, 1'b0, 4'hF, 32'h0, rd, er);
        check("status_after_reset", rd, 32'h0000_0001);
        bus_op(BASE + 32'h10, 1'b0, 4'hF, 32'h0, rd, er);
        check("cycles_at_grant", rd, 32'd11);

        for (int i = 0; i < NVEC; i++) begin
            bus_op(vecs[i].addr, vecs[i].we, vecs[i].be, vecs[i].wdata, rd, er);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
            check_b($sformatf("vec%0d_err", i), er, vecs[i].err);
        end
        check_b("vec_no_pass", tests_passed_o, 1'b0);
        check_b("vec_no_exit", exit_valid_o, 1'b0);
        check_b("vec_no_push", char_valid_o, 1'b0);

        // Back-to-back reads: one transaction per cycle, rdata zero once rvalid drops.
        data_req_i = 1'b1; data_addr_i = BASE + 32'h14; data_we_i = 1'b0; data_be_i = 4'hF;
        for (int i = 0; i < 3; i++) begin
            step(g, cyc, cnt, dn);
            check_b("b2b_gnt", g, 1'b1);
            check_b("b2b_rvalid", data_rvalid_o, 1'b1);
            check("b2b_rdata", data_rdata_o, 32'h1);
        end
        data_req_i = 1'b0;
        step(g, cyc, cnt, dn);
        check_b("b2b_rvalid_drop", data_rvalid_o, 1'b0);
        check("b2b_rdata_drop", data_rdata_o, 32'h0);

        // "Hi" with the consumer always ready.
        char_ready_i = 1'b1;
        pops0 = n_pops;
        bus_op(BASE, 1'b1, 4'h1, 32'h48, rd, er);
        bus_op(BASE, 1'b1, 4'h1, 32'h69, rd, er);
        idle(3);
        check("hi_pops", n_pops - pops0, 2);
        check_b("hi_empty", char_valid_o, 1'b0);

        // Fill to full with the consumer stalled; the ninth write waits for a pop.
        char_ready_i = 1'b0;
        pops0 = n_pops;
        for (int i = 0; i < DEPTH; i++) bus_op(BASE, 1'b1, 4'h1, 32'hA0 + i, rd, er);
        bus_op(BASE + 32'h14, 1'b0, 4'hF, 32'h0, rd, er);
        check("status_full", rd, 32'h0000_0802);
        data_req_i = 1'b1; data_addr_i = BASE; data_we_i = 1'b1; data_be_i = 4'h1;
        data_wdata_i = 32'hA8;
        step(g, cyc, cnt, dn);
        check_b("full_gnt_1", g, 1'b0);
        step(g, cyc, cnt, dn);
        check_b("full_gnt_2", g, 1'b0);
        char_ready_i = 1'b1;
        step(g, cyc, cnt, dn);
        check_b("full_gnt_pop_cycle", g, 1'b0);
        step(g, cyc, cnt, dn);
        check_b("full_gnt_after_pop", g, 1'b1);
        data_req_i = 1'b0;
        if (g) mq.push_back(8'hA8);
        check_b("full_rvalid", data_rvalid_o, 1'b1);
        idle(12);
        check("full_pops", n_pops - pops0, 9);
        check_b("full_drained", char_valid_o, 1'b0);

        // Pass wins; a later exit is accepted but ignored.
        do_reset();
        bus_op(BASE + 32'h04, 1'b1, 4'hF, MAGIC, rd, er);
        check_b("pass_set", tests_passed_o, 1'b1);
        bus_op(BASE + 32'h08, 1'b1, 4'hF, 32'd42, rd, er);
        check_b("pass_exit_ignored", exit_valid_o, 1'b0);
        check("pass_exit_value", exit_value_o, 32'h0);

        // Exit wins; a later fail is ignored.
        do_reset();
        bus_op(BASE + 32'h08, 1'b1, 4'hF, 32'd3, rd, er);
        check_b("exit_set", exit_valid_o, 1'b1);
        check("exit_value", exit_value_o, 32'd3);
        bus_op(BASE + 32'h04, 1'b1, 4'hF, 32'd1, rd, er);
        check_b("exit_fail_ignored", tests_failed_o, 1'b0);

        // Fail wins; pass afterwards ignored; STATUS reports the sticky bit.
        do_reset();
        bus_op(BASE + 32'h04, 1'b1, 4'hF, 32'd1, rd, er);
        check_b("fail_set", tests_failed_o, 1'b1);
        bus_op(BASE + 32'h04, 1'b1, 4'hF, MAGIC, rd, er);
        check_b("fail_pass_ignored", tests_passed_o, 1'b0);
        bus_op(BASE + 32'h14, 1'b0, 4'hF, 32'h0, rd, er);
        check("status_sticky", rd, 32'h0001_0001);

        // Reset with a grant outstanding and bytes buffered.
        for (int i = 0; i < 3; i++) bus_op(BASE, 1'b1, 4'h1, 32'h30 + i, rd, er);
        data_req_i = 1'b1; data_addr_i = BASE + 32'h14; data_we_i = 1'b0; data_be_i = 4'hF;
        #4;
        check_b("mid_rst_gnt", data_gnt_o, 1'b1);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        data_req_i = 1'b0;
        #1;
        check_all_zero("mid_rst");
        @(negedge clk_i);
        do_reset();
        step(g, cyc, cnt, dn);
        check_b("post_rst_rvalid", data_rvalid_o, 1'b0);

        // Randomized traffic against the model.
        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int i = 0; i < 80; i++) begin
                kind = $urandom_range(0, 15);
                char_ready_i = 1'($urandom_range(0, 1));
                addr = BASE; we = 1'b1; be = 4'hF; wd = $urandom;
                if (kind <= 6) begin
                    be = 4'($urandom_range(0, 15));
                end else if (kind <= 8) begin
                    addr = BASE + 32'h14; we = 1'b0;
                end else if (kind <= 10) begin
                    addr = BASE + 32'h10; we = 1'b0;
                end else if (kind <= 12) begin
                    addr = BASE + (kind == 11 ? 32'h04 : 32'h08);
                    case ($urandom_range(0, 3))
                        0: wd = MAGIC;
                        1: wd = 32'd1;
                        default: ;
                    endcase
                    if ($urandom_range(0, 3) == 0) be = 4'($urandom_range(0, 15));
                end else if (kind <= 14) begin
                    addr = (kind == 13) ? (BASE | 32'($urandom_range(0, 255))) : $urandom;
                    we = 1'($urandom_range(0, 1));
                    be = 4'($urandom_range(0, 15));
                end
                if (kind == 15) begin
                    idle($urandom_range(1, 3));
                end else begin
                    if (addr[31:8] == BASE[31:8] && addr[7:0] == 8'h00 && we && be[0]
                        && mq.size() >= DEPTH) char_ready_i = 1'b1;
                    bus_op(addr, we, be, wd, rd, er);
                end
            end
            char_ready_i = 1'b1;
            idle(DEPTH + 2);
            check_b("rand_drained", char_valid_o, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
